// File: rtl/ram_fifo_ctrl.sv
// Streaming FIFO controller around a 1W/1R ram with 1-cycle read latency.
// A 2-entry skid buffer on the output hides the ram read latency.
module ram_fifo_ctrl #(
  parameter int ADD_SIZE  = 11,
  parameter int DATA_SIZE = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [DATA_SIZE-1:0] s_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [DATA_SIZE-1:0] m_data,
  output logic                 ram_write_en,
  output logic [ADD_SIZE-1:0]  ram_write_address,
  output logic [DATA_SIZE-1:0] ram_data_in,
  output logic                 ram_read_en,
  output logic [ADD_SIZE-1:0]  ram_read_address,
  input  logic [DATA_SIZE-1:0] ram_data_out,
  output logic [ADD_SIZE+1:0]  level,
  output logic                 full,
  output logic                 empty
);

  localparam logic [ADD_SIZE:0] FULL_CNT =
    {1'b1, {ADD_SIZE{1'b0}}};

  logic [ADD_SIZE-1:0]  wr_ptr;
  logic [ADD_SIZE-1:0]  rd_ptr;
  logic [ADD_SIZE:0]    ram_cnt;
  logic                 inflight;
  logic [1:0]           buf_cnt;
  logic [DATA_SIZE-1:0] buf0;
  logic [DATA_SIZE-1:0] buf1;

  logic       push;
  logic       pop;
  logic       issue;
  logic [1:0] occ;

  assign full    = (ram_cnt == FULL_CNT);
  assign s_ready = !full;
  assign push    = s_valid & s_ready;

  assign m_valid = (buf_cnt != 2'd0);
  assign m_data  = buf0;
  assign pop     = m_valid & m_ready;

  // Outstanding words past the ram once this cycle's pop is taken.
  assign occ   = {1'b0, inflight} + buf_cnt - {1'b0, pop};
  assign issue = (ram_cnt != '0) && (occ < 2'd2);

  assign ram_write_en      = push;
  assign ram_write_address = wr_ptr;
  assign ram_data_in       = push ? s_data : '0;
  assign ram_read_en       = issue;
  assign ram_read_address  = rd_ptr;

  assign level = {1'b0, ram_cnt}
               + {{(ADD_SIZE+1){1'b0}}, inflight}
               + {{ADD_SIZE{1'b0}}, buf_cnt};
  assign empty = (level == '0);

  // Ram pointers, committed word count and read-in-flight flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      ram_cnt  <= '0;
      inflight <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + ADD_SIZE'(1);
      if (issue)
        rd_ptr <= rd_ptr + ADD_SIZE'(1);
      if (push && !issue)
        ram_cnt <= ram_cnt + (ADD_SIZE+1)'(1);
      else if (issue && !push)
        ram_cnt <= ram_cnt - (ADD_SIZE+1)'(1);
      inflight <= issue;
    end
  end

  // Skid buffer: buf0 is the oldest entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_cnt <= 2'd0;
      buf0    <= '0;
      buf1    <= '0;
    end else begin
      unique case (1'b1)
        (pop && inflight): begin
          if (buf_cnt == 2'd1) begin
            buf0 <= ram_data_out;
          end else begin
            buf0 <= buf1;
            buf1 <= ram_data_out;
          end
        end
        (pop && !inflight): begin
          buf0    <= buf1;
          buf_cnt <= buf_cnt - 2'd1;
        end
        (!pop && inflight): begin
          if (buf_cnt == 2'd0)
            buf0 <= ram_data_out;
          else
            buf1 <= ram_data_out;
          buf_cnt <= buf_cnt + 2'd1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Directed bench for ram_fifo_ctrl with a ram model
// and a queue scoreboard of accepted words.
module tb_ram_fifo_ctrl;

  localparam int AW    = 11;
  localparam int DW    = 32;
  localparam int DEPTH = 2048;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          ram_write_en;
  logic [AW-1:0] ram_write_address;
  logic [DW-1:0] ram_data_in;
  logic          ram_read_en;
  logic [AW-1:0] ram_read_address;
  logic [DW-1:0] ram_data_out;
  logic [AW+1:0] level;
  logic          full;
  logic          empty;

  ram_fifo_ctrl #(.ADD_SIZE(AW), .DATA_SIZE(DW)) dut (
    .clk               (clk),
    .rst               (rst),
    .s_valid           (s_valid),
    .s_ready           (s_ready),
    .s_data            (s_data),
    .m_valid           (m_valid),
    .m_ready           (m_ready),
    .m_data            (m_data),
    .ram_write_en      (ram_write_en),
    .ram_write_address (ram_write_address),
    .ram_data_in       (ram_data_in),
    .ram_read_en       (ram_read_en),
    .ram_read_address  (ram_read_address),
    .ram_data_out      (ram_data_out),
    .level             (level),
    .full              (full),
    .empty             (empty)
  );

  always #5 clk = ~clk;

  // Ram model: one write port, one read port, 1-cycle read latency.
  logic [DW-1:0] mem [0:DEPTH-1];
  always @(posedge clk) begin
    if (ram_write_en)
      mem[ram_write_address] <= ram_data_in;
    if (ram_read_en)
      ram_data_out <= mem[ram_read_address];
  end

  int passed = 0;
  int total  = 0;
  logic [DW-1:0] sb [$];
  int cyc = 0;
  int pushes = 0;
  int pops = 0;
  int first_pop = -1;
  int last_pop = -1;
  logic [DW-1:0] first_data;
  logic wrap_w, wrap_r, seen_wa, seen_ra;
  logic [AW-1:0] last_wa, last_ra;
  int t0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d",
                tag, obs, exp);
  endtask

  // One clock: sample handshakes before the edge, then advance.
  task automatic tick();
    logic [DW-1:0] e;
    #2;
    if (!rst) begin
      if (ram_write_en) begin
        if (seen_wa && last_wa == AW'(DEPTH-1)
            && ram_write_address == '0)
          wrap_w = 1'b1;
        last_wa = ram_write_address;
        seen_wa = 1'b1;
      end
      if (ram_read_en) begin
        if (seen_ra && last_ra == AW'(DEPTH-1)
            && ram_read_address == '0)
          wrap_r = 1'b1;
        last_ra = ram_read_address;
        seen_ra = 1'b1;
      end
      if (s_valid && s_ready) begin
        sb.push_back(s_data);
        pushes++;
      end
      if (m_valid && m_ready) begin
        pops++;
        if (first_pop < 0) begin
          first_pop  = cyc;
          first_data = m_data;
        end
        last_pop = cyc;
        chk("sb_nonempty", 64'(sb.size() != 0), 64'(1));
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("m_data", 64'(m_data), 64'(e));
        end
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    chk("drain_done", 64'(sb.size()), 64'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    wrap_w = 0; wrap_r = 0; seen_wa = 0; seen_ra = 0;
    last_wa = '0; last_ra = '0; first_data = '0;
    @(negedge clk);
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_s_ready", 64'(s_ready), 64'(1));
    chk("rst_m_valid", 64'(m_valid), 64'(0));
    chk("rst_empty", 64'(empty), 64'(1));
    chk("rst_full", 64'(full), 64'(0));
    chk("rst_level", 64'(level), 64'(0));
    chk("rst_wen", 64'(ram_write_en), 64'(0));
    chk("rst_ren", 64'(ram_read_en), 64'(0));
    tick();

    // Single word latency.
    m_ready = 1'b1; s_valid = 1'b1; s_data = 244;
    first_pop = -1; t0 = cyc;
    #1;
    chk("sw_wen", 64'(ram_write_en), 64'(1));
    chk("sw_waddr", 64'(ram_write_address), 64'(0));
    chk("sw_din", 64'(ram_data_in), 64'(244));
    tick();
    s_valid = 1'b0; s_data = '0;
    #1;
    chk("sw_ren", 64'(ram_read_en), 64'(1));
    chk("sw_raddr", 64'(ram_read_address), 64'(0));
    chk("sw_mv_n1", 64'(m_valid), 64'(0));
    tick();
    #1;
    chk("sw_mv_n2", 64'(m_valid), 64'(0));
    tick();
    #1;
    chk("sw_mv_n3", 64'(m_valid), 64'(1));
    chk("sw_md_n3", 64'(m_data), 64'(244));
    tick();
    #1;
    chk("sw_lat", 64'(first_pop - t0), 64'(3));
    chk("sw_empty", 64'(empty), 64'(1));
    chk("sw_mv_after", 64'(m_valid), 64'(0));

    // Back-to-back streaming.
    first_pop = -1; pops = 0; t0 = cyc;
    for (int i = 0; i < 100; i++) begin
      s_valid = 1'b1;
      s_data = DW'(i);
      tick();
    end
    s_valid = 1'b0;
    drain(50);
    chk("st_count", 64'(pops), 64'(100));
    chk("st_lat", 64'(first_pop - t0), 64'(3));
    chk("st_nogap", 64'(last_pop - first_pop), 64'(99));

    // Fill under back-pressure, then drain.
    m_ready = 1'b0; pushes = 0; wrap_w = 0; wrap_r = 0;
    for (int i = 0; i < DEPTH + 10; i++) begin
      s_valid = 1'b1;
      s_data = 32'h1000_0000 + DW'(i);
      tick();
    end
    s_valid = 1'b0;
    #1;
    chk("fl_accepted", 64'(pushes), 64'(DEPTH + 2));
    chk("fl_full", 64'(full), 64'(1));
    chk("fl_level", 64'(level), 64'(DEPTH + 2));
    chk("fl_s_ready", 64'(s_ready), 64'(0));
    chk("fl_m_valid", 64'(m_valid), 64'(1));
    chk("fl_head", 64'(m_data), 64'(sb[0]));
    chk("fl_wwrap", 64'(wrap_w), 64'(1));
    tick();
    tick();
    #1;
    chk("fl_hold", 64'(m_data), 64'(32'h1000_0000));
    m_ready = 1'b1;
    drain(DEPTH + 50);
    #1;
    chk("fl_rwrap", 64'(wrap_r), 64'(1));
    chk("fl_empty", 64'(empty), 64'(1));
    chk("fl_level0", 64'(level), 64'(0));

    // Refill, then read and write together.
    m_ready = 1'b0;
    for (int i = 0; i < DEPTH + 5; i++) begin
      s_valid = 1'b1;
      s_data = 32'h3000_0000 + DW'(i);
      tick();
    end
    #1;
    chk("sim_s_ready0", 64'(s_ready), 64'(0));
    chk("sim_level_full", 64'(level), 64'(DEPTH + 2));
    m_ready = 1'b1;
    tick();
    #1;
    chk("sim_resume", 64'(s_ready), 64'(1));
    for (int k = 0; k < 8; k++) begin
      s_data = 32'h2000_0000 + DW'(k);
      #1;
      chk("sim_level", 64'(level), 64'(DEPTH + 1));
      chk("sim_s_ready", 64'(s_ready), 64'(1));
      tick();
    end
    s_valid = 1'b0;
    drain(DEPTH + 50);

    // Reset in the middle of a stream.
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1;
      s_data = 100 + DW'(i);
      tick();
    end
    s_valid = 1'b0;
    #1;
    chk("mr_level5", 64'(level), 64'(5));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    seen_wa = 0; seen_ra = 0;
    #1;
    chk("mr_level0", 64'(level), 64'(0));
    chk("mr_m_valid", 64'(m_valid), 64'(0));
    chk("mr_ren", 64'(ram_read_en), 64'(0));
    m_ready = 1'b1; s_valid = 1'b1; s_data = 7;
    first_pop = -1;
    tick();
    s_valid = 1'b0; s_data = '0;
    drain(20);
    chk("mr_first", 64'(first_data), 64'(7));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
